// File: rtl/frontmon_pkg.sv
// Shared types and constants for the front-panel monitor scheduler.
// Holds the legal-mode mask, state encodings and the off code.
package frontmon_pkg;

   localparam logic [13:0] LEGAL = 14'h257F;
   localparam logic [3:0] MODE_OFF = 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GUARD  = 2'd1,
      ST_ACTIVE = 2'd2
   } state_t;

   // Bit m of the widened mask says whether mode code m is legal.
   function automatic logic is_legal(input logic [3:0] m);
      logic [15:0] lv;
      lv = {1'b0, LEGAL, 1'b0};
      return lv[m];
   endfunction

endpackage

// File: rtl/frontmon_nextmode.sv
// Wrap-around priority search for the next enabled monitor mode.
// Searches cur+1 .. 14, then 1 .. cur; cur=0 starts at mode 1.
module frontmon_nextmode
   import frontmon_pkg::*;
(
   input  logic [3:0]  cur,
   input  logic [13:0] mask,
   output logic [3:0]  nxt,
   output logic        none
);

   logic [4:0]  idx;
   logic [15:0] maskv;

   // Scan from farthest to nearest so the nearest hit wins.
   always_comb begin
      nxt   = MODE_OFF;
      none  = 1'b1;
      idx   = '0;
      maskv = {2'b00, mask};
      for (int k = 14; k >= 1; k--) begin
         idx = 5'(cur) + 5'(k);
         if (idx > 5'd14) idx = idx - 5'd14;
         if (maskv[4'(idx - 5'd1)]) begin
            nxt  = 4'(idx);
            none = 1'b0;
         end
      end
   end

endmodule

// File: rtl/frontmon_sched.sv
// Front-panel monitor mode scheduler: static mode or auto-scan, with a
// zero-code guard between modes. Optional FREEZE support: FRONTMON_FREEZE_EN.
module frontmon_sched
   import frontmon_pkg::*;
#(
   parameter int TMR     = 0,
   parameter int GUARD   = 4,
   parameter int DWELL_W = 16
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               MODE_WR,
   input  logic [3:0]         MODE_DIN,
   input  logic               SCAN_EN,
   input  logic [13:0]        SCAN_MASK,
   input  logic [DWELL_W-1:0] DWELL,
   input  logic               FREEZE,
   output logic [3:0]         MODECODE,
   output logic               MODE_VALID,
   output logic               SWITCH_STB,
   output logic [3:0]         STAT_MODE
);

   typedef struct packed {
      state_t             st;
      logic [3:0]         cur;
      logic [3:0]         tgt;
      logic [7:0]         gcnt;
      logic [DWELL_W-1:0] dcnt;
      logic [3:0]         stat;
      logic               scan_q;
      logic               stb;
   } ctl_t;

   localparam int CW = $bits(ctl_t);
   localparam logic [7:0] GLOAD = 8'(GUARD);

   ctl_t               q, d;
   logic [CW-1:0]      qv;
   logic [3:0]         stat_n, sd, base, nm, g_tgt;
   logic [13:0]        cand;
   logic [15:0]        candv;
   logic [DWELL_W-1:0] dw;
   logic               none, flip, frz, g_go, go_idle, cnt;

`ifdef FRONTMON_FREEZE_EN
   assign frz = FREEZE;
`else
   logic unused_freeze;
   assign unused_freeze = FREEZE;
   assign frz = 1'b0;
`endif

   if (TMR != 0) begin : g_tmr
      logic [CW-1:0] r0, r1, r2;
      // Three copies of the control state, voted bitwise.
      always_ff @(posedge CLK) begin
         if (RST) begin
            r0 <= '0;
            r1 <= '0;
            r2 <= '0;
         end else begin
            r0 <= d;
            r1 <= d;
            r2 <= d;
         end
      end
      assign qv = (r0 & r1) | (r0 & r2) | (r1 & r2);
   end else begin : g_single
      logic [CW-1:0] r0;
      // Single copy of the control state.
      always_ff @(posedge CLK) begin
         if (RST) r0 <= '0;
         else     r0 <= d;
      end
      assign qv = r0;
   end

   assign q = ctl_t'(qv);

   assign cand  = SCAN_MASK & LEGAL;
   assign candv = {1'b0, cand, 1'b0};
   assign flip  = SCAN_EN != q.scan_q;
   assign dw    = (DWELL == '0) ? DWELL_W'(1) : DWELL;

   assign base = (flip || q.st == ST_IDLE) ? MODE_OFF :
                 (q.st == ST_ACTIVE) ? q.cur : q.tgt;

   frontmon_nextmode u_next (
      .cur  (base),
      .mask (cand),
      .nxt  (nm),
      .none (none)
   );

   // Decide the next state: idle, (re)start guard, count guard, or dwell.
   always_comb begin
      d        = q;
      d.stb    = 1'b0;
      d.scan_q = SCAN_EN;
      stat_n   = MODE_WR ? MODE_DIN : q.stat;
      d.stat   = stat_n;
      sd       = is_legal(stat_n) ? stat_n : MODE_OFF;
      g_go     = 1'b0;
      g_tgt    = MODE_OFF;
      go_idle  = 1'b0;
      cnt      = 1'b0;
      if (!SCAN_EN) begin
         if (sd == MODE_OFF) begin
            go_idle = 1'b1;
         end else if (flip) begin
            g_go  = 1'b1;
            g_tgt = sd;
         end else begin
            unique case (q.st)
               ST_ACTIVE: begin
                  g_go  = q.cur != sd;
                  g_tgt = sd;
               end
               ST_GUARD: begin
                  g_go  = q.tgt != sd;
                  g_tgt = sd;
                  cnt   = q.tgt == sd;
               end
               ST_IDLE: begin
                  g_go  = 1'b1;
                  g_tgt = sd;
               end
               default: go_idle = 1'b1;
            endcase
         end
      end else begin
         g_tgt = nm;
         if (none) begin
            go_idle = 1'b1;
         end else if (flip || q.st == ST_IDLE) begin
            g_go = 1'b1;
         end else begin
            unique case (q.st)
               ST_GUARD: begin
                  g_go = !candv[q.tgt];
                  cnt  = candv[q.tgt];
               end
               ST_ACTIVE: begin
                  if (!candv[q.cur]) begin
                     g_go = 1'b1;
                  end else if (frz) begin
                     d.dcnt = q.dcnt;
                  end else if (q.dcnt <= DWELL_W'(1)) begin
                     if (nm == q.cur) d.dcnt = dw;
                     else             g_go = 1'b1;
                  end else begin
                     d.dcnt = q.dcnt - DWELL_W'(1);
                  end
               end
               default: go_idle = 1'b1;
            endcase
         end
      end
      if (go_idle) begin
         d.st = ST_IDLE;
      end else if (g_go) begin
         d.st   = ST_GUARD;
         d.tgt  = g_tgt;
         d.gcnt = GLOAD;
      end else if (cnt) begin
         if (q.gcnt <= 8'd1) begin
            d.st   = ST_ACTIVE;
            d.cur  = q.tgt;
            d.dcnt = dw;
            d.stb  = 1'b1;
         end else begin
            d.gcnt = q.gcnt - 8'd1;
         end
      end
   end

   assign MODE_VALID = q.st == ST_ACTIVE;
   assign MODECODE   = MODE_VALID ? q.cur : MODE_OFF;
   assign SWITCH_STB = q.stb;
   assign STAT_MODE  = q.stat;

endmodule

// File: tb/tb_frontmon_sched.sv
// Scoreboard bench for frontmon_sched: per-cycle expected MODECODE,
// MODE_VALID and SWITCH_STB are queued with the stimulus and popped each cycle.
module tb_frontmon_sched;

`ifdef FRONTMON_FREEZE_EN
   localparam int FEXT = 20;
`else
   localparam int FEXT = 0;
`endif

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        MODE_WR = 1'b0;
   logic [3:0]  MODE_DIN = '0;
   logic        SCAN_EN = 1'b0;
   logic [13:0] SCAN_MASK = '0;
   logic [15:0] DWELL = '0;
   logic        FREEZE = 1'b0;
   logic [3:0]  MODECODE;
   logic        MODE_VALID;
   logic        SWITCH_STB;
   logic [3:0]  STAT_MODE;

   typedef struct {
      int         tn;
      logic [3:0] mc;
      logic       v;
      logic       s;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;

   frontmon_sched #(.TMR(0), .GUARD(4), .DWELL_W(16)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .MODE_WR    (MODE_WR),
      .MODE_DIN   (MODE_DIN),
      .SCAN_EN    (SCAN_EN),
      .SCAN_MASK  (SCAN_MASK),
      .DWELL      (DWELL),
      .FREEZE     (FREEZE),
      .MODECODE   (MODECODE),
      .MODE_VALID (MODE_VALID),
      .SWITCH_STB (SWITCH_STB),
      .STAT_MODE  (STAT_MODE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic push(input int tn, input logic [3:0] m, input int n,
                       input logic s);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.tn = tn;
         e.mc = m;
         e.v  = m != 4'd0;
         e.s  = s && (i == 0);
         sb.push_back(e);
      end
   endtask

   task automatic cyc();
      exp_t e;
      @(posedge CLK);
      #1;
      if (sb.size() == 0) begin
         chk("sb_underflow", 1, 0);
      end else begin
         e = sb.pop_front();
         chk($sformatf("t%0d_mc", e.tn), 32'(MODECODE), 32'(e.mc));
         chk($sformatf("t%0d_valid", e.tn), 32'(MODE_VALID), 32'(e.v));
         chk($sformatf("t%0d_stb", e.tn), 32'(SWITCH_STB), 32'(e.s));
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_mc", 32'(MODECODE), 0);
      chk("rst_valid", 32'(MODE_VALID), 0);
      chk("rst_stb", 32'(SWITCH_STB), 0);
      chk("rst_stat", 32'(STAT_MODE), 0);
      RST = 1'b0;

      // 1: static write of mode 3
      MODE_DIN = 4'd3;
      MODE_WR  = 1'b1;
      push(1, 4'd0, 4, 1'b0);
      push(1, 4'd3, 6, 1'b1);
      cyc();
      MODE_WR = 1'b0;
      run(9);
      chk("t1_stat", 32'(STAT_MODE), 3);

      // 2: illegal code drops straight to idle
      MODE_DIN = 4'd8;
      MODE_WR  = 1'b1;
      push(2, 4'd0, 3, 1'b0);
      cyc();
      MODE_WR = 1'b0;
      run(2);
      chk("t2_stat", 32'(STAT_MODE), 8);

      // 3: scan 1 -> 9 -> 14 -> 1
      SCAN_MASK = 14'h2101;
      DWELL     = 16'd10;
      SCAN_EN   = 1'b1;
      push(3, 4'd0, 4, 1'b0);
      push(3, 4'd1, 10, 1'b1);
      push(3, 4'd0, 4, 1'b0);
      push(3, 4'd9, 10, 1'b1);
      push(3, 4'd0, 4, 1'b0);
      push(3, 4'd14, 10, 1'b1);
      push(3, 4'd0, 4, 1'b0);
      push(3, 4'd1, 3, 1'b1);
      run(49);

      // 4: current mode removed; single candidate 7 holds
      SCAN_MASK = 14'h0040;
      push(4, 4'd0, 4, 1'b0);
      push(4, 4'd7, 35, 1'b1);
      run(39);

      // 5: scan off together with a write of 2
      SCAN_EN  = 1'b0;
      MODE_DIN = 4'd2;
      MODE_WR  = 1'b1;
      push(5, 4'd0, 4, 1'b0);
      push(5, 4'd2, 20, 1'b1);
      cyc();
      MODE_WR = 1'b0;
      run(23);
      chk("t5_stat", 32'(STAT_MODE), 2);

      // 6: FREEZE mid-dwell
      SCAN_MASK = 14'h0006;
      DWELL     = 16'd10;
      SCAN_EN   = 1'b1;
      push(6, 4'd0, 4, 1'b0);
      push(6, 4'd2, 10, 1'b1);
      push(6, 4'd0, 4, 1'b0);
      push(6, 4'd3, 10 + FEXT, 1'b1);
      push(6, 4'd0, 4, 1'b0);
      push(6, 4'd2, 10, 1'b1);
      run(21);
      FREEZE = 1'b1;
      run(20);
      FREEZE = 1'b0;
      run(1 + FEXT);

      // 7: new request during guard restarts the guard
      SCAN_EN  = 1'b0;
      MODE_DIN = 4'd5;
      MODE_WR  = 1'b1;
      push(7, 4'd0, 6, 1'b0);
      push(7, 4'd6, 4, 1'b1);
      cyc();
      MODE_WR = 1'b0;
      cyc();
      MODE_DIN = 4'd6;
      MODE_WR  = 1'b1;
      cyc();
      MODE_WR = 1'b0;
      run(7);

      // 8: rewriting the active mode is silent
      MODE_WR = 1'b1;
      push(8, 4'd6, 3, 1'b0);
      cyc();
      MODE_WR = 1'b0;
      run(2);

      // 9: reset mid-operation
      RST = 1'b1;
      push(9, 4'd0, 2, 1'b0);
      cyc();
      RST = 1'b0;
      run(1);
      chk("t9_stat", 32'(STAT_MODE), 0);

      // 10: DWELL=0 acts as 1, empty set idles, illegal bits ignored
      SCAN_MASK = 14'h0003;
      DWELL     = 16'd0;
      SCAN_EN   = 1'b1;
      push(10, 4'd0, 4, 1'b0);
      push(10, 4'd1, 1, 1'b1);
      push(10, 4'd0, 4, 1'b0);
      push(10, 4'd2, 1, 1'b1);
      push(10, 4'd0, 4, 1'b0);
      push(10, 4'd1, 1, 1'b1);
      run(15);
      SCAN_MASK = 14'h0000;
      push(10, 4'd0, 3, 1'b0);
      run(3);
      SCAN_MASK = 14'h0480;
      push(10, 4'd0, 4, 1'b0);
      push(10, 4'd11, 3, 1'b1);
      run(7);

      chk("sb_left", 32'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
